// File: rtl/motion_estimator_if.sv
// rtl/motion_estimator_if.sv - handshake, RAM address and result bundle of the motion estimator
// slave modport faces the engine; master faces the requester / pixel RAMs.
interface motion_estimator_if #(
    parameter int MACRO_DIM = 16
);
    logic                       start;
    logic                       ready;
    logic                       valid;
    logic                       done;
    logic [MACRO_DIM*8-1:0]     pixel_cpr_in;
    logic [(MACRO_DIM+1)*8-1:0] pixel_spr_in;
    logic [5:0]                 addr;
    logic [5:0]                 amt;
    logic [15:0]                min_sad;
    logic [5:0]                 mv_x;
    logic [5:0]                 mv_y;

    modport master (
        output start, pixel_cpr_in, pixel_spr_in,
        input  ready, valid, done, addr, amt, min_sad, mv_x, mv_y
    );

    modport slave (
        input  start, pixel_cpr_in, pixel_spr_in,
        output ready, valid, done, addr, amt, min_sad, mv_x, mv_y
    );
endinterface

// File: rtl/motion_estimator.sv
// rtl/motion_estimator.sv - full-search SAD motion estimator over a lane-rotating search strip
// Optional early candidate abandonment: define ME_EARLY_TERM_EN.
module motion_estimator #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
) (
    input  logic                i_clk,
    input  logic                i_rst,
    motion_estimator_if.slave   bus
);
    localparam int DY_MAX = SEARCH_DIM - MACRO_DIM;
    localparam int RW     = $clog2(MACRO_DIM);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEARCH, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [7:0]     r_cur [MACRO_DIM][MACRO_DIM];
    logic [5:0]     r_addr, r_amt, r_dy;
    logic [RW-1:0]  r_row;
    logic [15:0]    r_acc, r_best, r_min_sad;
    logic [5:0]     r_best_x, r_best_y, r_mv_x, r_mv_y;
    logic           r_valid;

    logic [15:0]    w_rowsad, w_total;
    logic           w_row_last, w_better, w_cand_end, w_last_cand, w_load_last;

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Lane MACRO_DIM of the search port is the wrap-around spare and never contributes.
    always_comb begin
        w_rowsad = '0;
        for (int l = 0; l < MACRO_DIM; l++) begin
            w_rowsad = w_rowsad + 16'(absdiff(r_cur[r_row][l], bus.pixel_spr_in[l*8 +: 8]));
        end
    end

    assign w_total     = r_acc + w_rowsad;
    assign w_row_last  = (r_row == RW'(MACRO_DIM - 1));
    assign w_better    = (w_total < r_best);
    assign w_last_cand = (r_amt == 6'(MACRO_DIM)) && (r_dy == 6'(DY_MAX));
    assign w_load_last = (r_addr == 6'(MACRO_DIM - 1));

`ifdef ME_EARLY_TERM_EN
    assign w_cand_end = w_row_last || !w_better;
`else
    assign w_cand_end = w_row_last;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_LOAD;
            S_LOAD:   if (w_load_last) w_next = S_SEARCH;
            S_SEARCH: if (w_cand_end && w_last_cand) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (r_state == S_IDLE);
        bus.done  = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_LOAD) begin
            for (int l = 0; l < MACRO_DIM; l++) begin
                r_cur[r_addr[RW-1:0]][l] <= bus.pixel_cpr_in[l*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr    <= '0;
            r_amt     <= '0;
            r_dy      <= '0;
            r_row     <= '0;
            r_acc     <= '0;
            r_best    <= '1;
            r_best_x  <= '0;
            r_best_y  <= '0;
            r_min_sad <= '0;
            r_mv_x    <= '0;
            r_mv_y    <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_addr   <= '0;
                    r_amt    <= '0;
                    r_dy     <= '0;
                    r_row    <= '0;
                    r_acc    <= '0;
                    r_best   <= '1;
                    r_best_x <= '0;
                    r_best_y <= '0;
                    r_valid  <= 1'b0;
                end
                S_LOAD: r_addr <= w_load_last ? 6'd0 : r_addr + 6'd1;
                S_SEARCH: begin
                    if (w_row_last && w_better) begin
                        r_best   <= w_total;
                        r_best_x <= r_amt;
                        r_best_y <= r_dy;
                    end
                    if (w_cand_end) begin
                        r_acc <= '0;
                        r_row <= '0;
                        if (r_dy == 6'(DY_MAX)) begin
                            r_dy   <= '0;
                            r_addr <= '0;
                            r_amt  <= r_amt + 6'd1;
                        end else begin
                            r_dy   <= r_dy + 6'd1;
                            r_addr <= r_dy + 6'd1;
                        end
                    end else begin
                        r_acc  <= w_total;
                        r_row  <= r_row + RW'(1);
                        r_addr <= r_addr + 6'd1;
                    end
                    // The final candidate may itself be the winner, so publish from the live compare.
                    if (w_cand_end && w_last_cand) begin
                        r_valid   <= 1'b1;
                        r_min_sad <= (w_row_last && w_better) ? w_total : r_best;
                        r_mv_x    <= (w_row_last && w_better) ? r_amt   : r_best_x;
                        r_mv_y    <= (w_row_last && w_better) ? r_dy    : r_best_y;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.addr    = r_addr;
    assign bus.amt     = r_amt;
    assign bus.valid   = r_valid;
    assign bus.min_sad = r_min_sad;
    assign bus.mv_x    = r_mv_x;
    assign bus.mv_y    = r_mv_y;
endmodule

// File: tb/tb_motion_estimator.sv
// tb/tb_motion_estimator.sv - directed self-checking bench for motion_estimator
// Pixel RAMs and a brute-force SAD search model live in the bench.
module tb_motion_estimator;
    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int exp_sad, exp_x, exp_y;
    int lat;

    logic [7:0] cur_mem [16][16];
    logic [7:0] win_mem [48][17];

    motion_estimator_if #(.MACRO_DIM(16)) bus ();

    motion_estimator dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency RAMs: search port l returns column (l+amt) mod 17 of row addr.
    always_comb begin
        for (int l = 0; l < 16; l++) begin
            bus.pixel_cpr_in[l*8 +: 8] = cur_mem[bus.addr[3:0]][l];
        end
        for (int l = 0; l < 17; l++) begin
            if (int'(bus.addr) < 48)
                bus.pixel_spr_in[l*8 +: 8] = win_mem[int'(bus.addr)][(l + int'(bus.amt)) % 17];
            else
                bus.pixel_spr_in[l*8 +: 8] = 8'h00;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            n_done++;
            check("done_valid", int'(bus.valid), 1);
            check("done_ready", int'(bus.ready), 0);
            check("done_sad", int'(bus.min_sad), exp_sad);
            check("done_mv_x", int'(bus.mv_x), exp_x);
            check("done_mv_y", int'(bus.mv_y), exp_y);
        end
    end

    task automatic compute_model();
        int s;
        exp_sad = 65535;
        exp_x = 0;
        exp_y = 0;
        for (int dx = 0; dx <= 16; dx++) begin
            for (int dy = 0; dy <= 32; dy++) begin
                s = 0;
                for (int r = 0; r < 16; r++) begin
                    for (int c = 0; c < 16; c++) begin
                        int a, b;
                        a = int'(cur_mem[r][c]);
                        b = int'(win_mem[dy + r][(c + dx) % 17]);
                        s += (a > b) ? a - b : b - a;
                    end
                end
                if (s < exp_sad) begin
                    exp_sad = s;
                    exp_x = dx;
                    exp_y = dy;
                end
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, int'(bus.ready), 1);
        check({tag, "_valid"}, int'(bus.valid), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_addr"}, int'(bus.addr), 0);
        check({tag, "_amt"}, int'(bus.amt), 0);
        check({tag, "_sad"}, int'(bus.min_sad), 0);
        check({tag, "_mvx"}, int'(bus.mv_x), 0);
        check({tag, "_mvy"}, int'(bus.mv_y), 0);
    endtask

    task automatic check_lat(input string name, input int l, input bit must_beat);
`ifdef ME_EARLY_TERM_EN
        if (must_beat) check(name, int'(l > 0 && l < 8993), 1);
        else           check(name, int'(l > 0 && l <= 8993), 1);
`else
        check(name, l, 8993);
`endif
    endtask

    // Cycle n is the n-th clock period after the edge that samples start.
    task automatic run(input int pulse_at, input int rst_at, output int l);
        int n;
        int d0;
        d0 = n_done;
        l = -1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 1;
        while (n <= 20000) begin
            @(negedge clk);
            bus.start = (n == pulse_at);
            if (n == rst_at) begin
                bus.start = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_reset("mid_rst");
                rst = 1'b0;
                return;
            end
            if (bus.done) begin
                l = n;
                break;
            end
            @(posedge clk);
            n++;
        end
        bus.start = 1'b0;
        check("done_seen", int'(l > 0), 1);
        @(posedge clk);
        @(negedge clk);
        check("ready_after", int'(bus.ready), 1);
        check("done_one_cycle", int'(bus.done), 0);
        check("done_count", n_done - d0, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_mem[r][c] = 8'h00;
        for (int r = 0; r < 48; r++) for (int c = 0; c < 17; c++) win_mem[r][c] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Exact copy at dx=5, dy=10 over a flat 0xAA background; MB pixels are all distinct.
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_mem[r][c] = 8'(r * 16 + c);
        for (int r = 0; r < 48; r++) for (int c = 0; c < 17; c++) win_mem[r][c] = 8'hAA;
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) win_mem[10 + r][(c + 5) % 17] = cur_mem[r][c];
        compute_model();
        check("model_exact_sad", exp_sad, 0);
        check("model_exact_x", exp_x, 5);
        check("model_exact_y", exp_y, 10);
        run(0, 0, lat);
        check_lat("exact_latency", lat, 1'b1);
        check("exact_sad", int'(bus.min_sad), 0);
        check("exact_mv_x", int'(bus.mv_x), 5);
        check("exact_mv_y", int'(bus.mv_y), 10);
        check("exact_valid_hold", int'(bus.valid), 1);

        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_mem[r][c] = 8'h00;
        for (int r = 0; r < 48; r++) for (int c = 0; c < 17; c++) win_mem[r][c] = 8'hFF;
        compute_model();
        check("model_max_sad", exp_sad, 65280);
        run(0, 0, lat);
        check_lat("max_latency", lat, 1'b0);
        check("max_sad", int'(bus.min_sad), 65280);
        check("max_mv_x", int'(bus.mv_x), 0);
        check("max_mv_y", int'(bus.mv_y), 0);

        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_mem[r][c] = 8'd12;
        for (int r = 0; r < 48; r++) for (int c = 0; c < 17; c++) win_mem[r][c] = 8'd10;
        compute_model();
        check("model_flat_sad", exp_sad, 512);
        run(0, 0, lat);
        check_lat("flat_latency", lat, 1'b0);
        check("flat_sad", int'(bus.min_sad), 512);
        check("flat_mv_x", int'(bus.mv_x), 0);
        check("flat_mv_y", int'(bus.mv_y), 0);

        // Textured data; a start pulse in the middle of SEARCH must be ignored.
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_mem[r][c] = 8'((r * 7 + c * 3) & 8'hFF);
        for (int r = 0; r < 48; r++) for (int c = 0; c < 17; c++) win_mem[r][c] = 8'(((r * 5) ^ (c * 11)) + r);
        compute_model();
        run(3000, 0, lat);
        check_lat("pulse_latency", lat, 1'b0);
        check("pulse_sad", int'(bus.min_sad), exp_sad);

        // Abort 4000 cycles into SEARCH, then rerun the same data.
        run(0, 16 + 4000, lat);
        check("abort_no_done", lat, -1);
        run(0, 0, lat);
        check_lat("rerun_latency", lat, 1'b0);
        check("rerun_mv_x", int'(bus.mv_x), exp_x);
        check("rerun_mv_y", int'(bus.mv_y), exp_y);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
